// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and character helpers for the LCD time writer.
package lcd_pkg;

    localparam int CNT_W = 24;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME_ADDR  = 8'h80;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_FRAME,
        ST_IDLE
    } top_state_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_SETUP,
        BW_STROBE,
        BW_SETTLE
    } bw_state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d <= 4'd9) return ASCII_ZERO + {4'd0, d};
        return ASCII_QMARK;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd1:    return CMD_DISP_ON;
            3'd2:    return CMD_ENTRY_MODE;
            3'd3:    return CMD_CLEAR;
            default: return CMD_FUNC_SET;
        endcase
    endfunction

    // Frame layout on the display: address, mil, cen, ':', dec, uni.
    function automatic logic [7:0] frame_char(input logic [2:0] idx, input logic [15:0] snap);
        case (idx)
            3'd1:    return digit_char(snap[15:12]);
            3'd2:    return digit_char(snap[11:8]);
            3'd3:    return ASCII_COLON;
            3'd4:    return digit_char(snap[7:4]);
            3'd5:    return digit_char(snap[3:0]);
            default: return CMD_HOME_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one HD44780 byte: setup, enable strobe, then settle (longer after a clear).
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SU_CYC  = 2,
    parameter int E_CYC   = 12,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    output logic       o_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_e
);

    bw_state_t        r_state;
    bw_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_phase_last;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_is_clear;
    logic             w_phase_end;
    logic             w_accept;

    always_comb begin
        w_phase_last = '0;
        case (r_state)
            BW_SETUP:  w_phase_last = CNT_W'(SU_CYC - 1);
            BW_STROBE: w_phase_last = CNT_W'(E_CYC - 1);
            BW_SETTLE: w_phase_last = r_is_clear ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
            default:   w_phase_last = '0;
        endcase
    end

    assign w_phase_end = (r_cnt == w_phase_last);
    assign o_done      = (r_state == BW_SETTLE) && w_phase_end;
    // Handshake: i_start is taken while idle or in the final settle cycle (o_done high),
    // so the caller can chain bytes with no dead cycle; i_data/i_rs are sampled only then.
    assign w_accept    = i_start && ((r_state == BW_IDLE) || o_done);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        case (r_state)
            BW_IDLE: w_cnt_next = '0;
            BW_SETUP: if (w_phase_end) begin
                w_state_next = BW_STROBE;
                w_cnt_next   = '0;
            end
            BW_STROBE: if (w_phase_end) begin
                w_state_next = BW_SETTLE;
                w_cnt_next   = '0;
            end
            BW_SETTLE: if (w_phase_end) begin
                w_state_next = BW_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = BW_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (w_accept) begin
            w_state_next = BW_SETUP;
            w_cnt_next   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= BW_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_rs       <= 1'b0;
            r_is_clear <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_data     <= i_data;
                r_rs       <= i_rs;
                r_is_clear <= !i_rs && (i_data == CMD_CLEAR);
            end
        end
    end

    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_e    = (r_state == BW_STROBE);

endmodule

// File: rtl/lcd_time_writer.sv
// Powers up an HD44780, initialises it, and rewrites "MC:DU" whenever the BCD time changes.
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter int PWR_CYC = 750000,
    parameter int SU_CYC  = 2,
    parameter int E_CYC   = 12,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mil,
    input  logic [3:0] cen,
    input  logic [3:0] dec,
    input  logic [3:0] uni,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       busy,
    output logic       frame_done
);

    top_state_t       r_state;
    top_state_t       w_state_next;
    logic [CNT_W-1:0] r_pwr_cnt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_next;
    logic [15:0]      r_snap;
    logic [15:0]      w_live;
    logic             w_snap_load;
    logic             w_start;
    logic [7:0]       w_byte;
    logic             w_rs;
    logic             w_done;
    logic             w_frame_done;

    assign w_live = {mil, cen, dec, uni};

    lcd_byte_writer #(
        .SU_CYC (SU_CYC),
        .E_CYC  (E_CYC),
        .CMD_CYC(CMD_CYC),
        .CLR_CYC(CLR_CYC)
    ) u_writer (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_start   (w_start),
        .i_data    (w_byte),
        .i_rs      (w_rs),
        .o_done    (w_done),
        .o_lcd_data(lcd_data),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_e   (lcd_e)
    );

    // Each next byte is launched in the cycle before it must appear, so bytes run back to back.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_start      = 1'b0;
        w_byte       = 8'h00;
        w_rs         = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_PWR_WAIT: if (r_pwr_cnt == CNT_W'(PWR_CYC - 1)) begin
                w_start      = 1'b1;
                w_byte       = init_cmd(3'd0);
                w_state_next = ST_INIT;
                w_idx_next   = 3'd0;
            end
            ST_INIT: if (w_done) begin
                w_start = 1'b1;
                if (r_idx == 3'd3) begin
                    w_byte       = CMD_HOME_ADDR;
                    w_state_next = ST_FRAME;
                    w_idx_next   = 3'd0;
                end else begin
                    w_byte     = init_cmd(r_idx + 3'd1);
                    w_idx_next = r_idx + 3'd1;
                end
            end
            ST_FRAME: if (w_done) begin
                if (r_idx == 3'd5) begin
                    w_frame_done = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_start    = 1'b1;
                    w_byte     = frame_char(r_idx + 3'd1, r_snap);
                    w_rs       = 1'b1;
                    w_idx_next = r_idx + 3'd1;
                end
            end
            ST_IDLE: if (w_live != r_snap) begin
                w_start      = 1'b1;
                w_byte       = CMD_HOME_ADDR;
                w_state_next = ST_FRAME;
                w_idx_next   = 3'd0;
            end
            default: w_state_next = ST_PWR_WAIT;
        endcase
    end

    assign w_snap_load = (w_state_next == ST_FRAME) && (r_state != ST_FRAME);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_PWR_WAIT;
            r_pwr_cnt <= '0;
            r_idx     <= '0;
            r_snap    <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (r_state == ST_PWR_WAIT) r_pwr_cnt <= r_pwr_cnt + 1'b1;
            else                        r_pwr_cnt <= '0;
            if (w_snap_load) r_snap <= w_live;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign frame_done = w_frame_done;
    assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed bench for lcd_time_writer with short timing parameters.
module tb_lcd_time_writer;

    localparam int PWR_CYC  = 10;
    localparam int SU_CYC   = 1;
    localparam int E_CYC    = 2;
    localparam int CMD_CYC  = 4;
    localparam int CLR_CYC  = 8;
    localparam int BYTE_CYC = 7;
    localparam int INIT_FD  = 83;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] mil = 4'd0, cen = 4'd0, dec = 4'd0, uni = 4'd0;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy, frame_done;

    lcd_time_writer #(
        .PWR_CYC(PWR_CYC), .SU_CYC(SU_CYC), .E_CYC(E_CYC),
        .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .mil(mil), .cen(cen), .dec(dec), .uni(uni),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Cycle number since reset release; cycle k is sampled after the k-th posedge.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int         obs_rise[$];
    int         obs_fall[$];
    int         obs_width[$];
    int         fd_q[$];
    logic [8:0] obs_byte[$];
    int         e_width = 0;
    int         hold_err = 0;
    logic       prev_e = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_e  = 1'b0;
            e_width = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                obs_rise.push_back(cyc);
                obs_byte.push_back({lcd_rs, lcd_data});
                e_width = 1;
            end else if (lcd_e) begin
                e_width++;
                if (obs_byte.size() > 0 && {lcd_rs, lcd_data} != obs_byte[$]) hold_err++;
            end else if (prev_e) begin
                obs_width.push_back(e_width);
                obs_fall.push_back(cyc);
            end
            if (frame_done) fd_q.push_back(cyc);
            prev_e = lcd_e;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    int         exp_rise_q[$];

    typedef struct {
        logic [8:0] rsd;
        int         rise;
    } init_vec_t;

    typedef struct {
        logic [3:0] mil, cen, dec, uni;
        logic [7:0] c_mil, c_cen, c_dec, c_uni;
    } frame_vec_t;

    init_vec_t  init_tab[4];
    frame_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_rise.delete();
        obs_fall.delete();
        obs_width.delete();
        obs_byte.delete();
        fd_q.delete();
    endtask

    task automatic wait_fd(input int budget, input string tag);
        int n;
        n = 0;
        while (fd_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        if (fd_q.size() == 0) fail(tag, "frame_done never pulsed");
    endtask

    task automatic push_frame(input int first_rise, input logic [7:0] cm, input logic [7:0] cc,
                              input logic [7:0] cd, input logic [7:0] cu);
        exp_q.push_back({1'b0, 8'h80}); exp_rise_q.push_back(first_rise);
        exp_q.push_back({1'b1, cm});    exp_rise_q.push_back(first_rise + 1 * BYTE_CYC);
        exp_q.push_back({1'b1, cc});    exp_rise_q.push_back(first_rise + 2 * BYTE_CYC);
        exp_q.push_back({1'b1, 8'h3A}); exp_rise_q.push_back(first_rise + 3 * BYTE_CYC);
        exp_q.push_back({1'b1, cd});    exp_rise_q.push_back(first_rise + 4 * BYTE_CYC);
        exp_q.push_back({1'b1, cu});    exp_rise_q.push_back(first_rise + 5 * BYTE_CYC);
    endtask

    task automatic compare_obs(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [8:0] e;
            int         r;
            e = exp_q.pop_front();
            r = exp_rise_q.pop_front();
            if (i < obs_byte.size()) begin
                check($sformatf("%s byte%0d rs_data", tag, i), obs_byte[i], e);
                check($sformatf("%s byte%0d rise", tag, i), obs_rise[i], r);
                if (i < obs_width.size())
                    check($sformatf("%s byte%0d e_width", tag, i), obs_width[i], E_CYC);
                else
                    fail($sformatf("%s byte%0d e_width", tag, i), "lcd_e pulse never ended");
            end else begin
                fail($sformatf("%s byte%0d", tag, i), "byte not observed");
            end
        end
    endtask

    // Low time after a pulse up to the next byte's data change: rise - setup - fall.
    task automatic check_settle(input string tag, input int idx, input int exp_cyc);
        if (obs_rise.size() > idx + 1 && obs_fall.size() > idx)
            check(tag, obs_rise[idx + 1] - SU_CYC - obs_fall[idx], exp_cyc);
        else
            fail(tag, "pulses missing");
    endtask

    task automatic check_power_up(input string tag, input logic [7:0] cm, input logic [7:0] cc,
                                  input logic [7:0] cd, input logic [7:0] cu);
        wait_fd(200, {tag, " frame_done"});
        if (fd_q.size() > 0) check({tag, " frame_done cycle"}, fd_q[0], INIT_FD);
        check({tag, " byte count"}, obs_byte.size(), 10);
        check_settle({tag, " cmd settle"}, 0, CMD_CYC);
        check_settle({tag, " clear settle"}, 3, CLR_CYC);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(init_tab[i].rsd);
            exp_rise_q.push_back(init_tab[i].rise);
        end
        push_frame(43, cm, cc, cd, cu);
        compare_obs(tag);
        tick();
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle lcd_e"}, lcd_e, 1'b0);
        check({tag, " idle data kept"}, {lcd_rs, lcd_data}, {1'b1, cu});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " lcd_e"}, lcd_e, 1'b0);
        check({tag, " lcd_rs"}, lcd_rs, 1'b0);
        check({tag, " lcd_rw"}, lcd_rw, 1'b0);
        check({tag, " lcd_data"}, lcd_data, 8'h00);
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;

        init_tab[0] = '{{1'b0, 8'h38}, 11};
        init_tab[1] = '{{1'b0, 8'h0C}, 18};
        init_tab[2] = '{{1'b0, 8'h06}, 25};
        init_tab[3] = '{{1'b0, 8'h01}, 32};

        vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h5, 8'h31, 8'h32, 8'h33, 8'h35};
        vecs[1] = '{4'hB, 4'h2, 4'h3, 4'h5, 8'h3F, 8'h32, 8'h33, 8'h35};
        vecs[2] = '{4'h9, 4'h0, 4'hF, 4'h8, 8'h39, 8'h30, 8'h3F, 8'h38};
        vecs[3] = '{4'h0, 4'hA, 4'h7, 4'h6, 8'h30, 8'h3F, 8'h37, 8'h36};

        mil = 4'd1; cen = 4'd2; dec = 4'd3; uni = 4'd4;
        repeat (3) tick();
        check_reset_outputs("reset");

        clear_obs();
        reset = 1'b0;
        check_power_up("power_up", 8'h31, 8'h32, 8'h33, 8'h34);

        for (int v = 0; v < 4; v++) begin
            clear_obs();
            c0 = cyc;
            mil = vecs[v].mil; cen = vecs[v].cen; dec = vecs[v].dec; uni = vecs[v].uni;
            check($sformatf("vec%0d busy before", v), busy, 1'b0);
            tick();
            check($sformatf("vec%0d busy next cycle", v), busy, 1'b1);
            wait_fd(100, $sformatf("vec%0d frame_done", v));
            if (fd_q.size() > 0) check($sformatf("vec%0d frame_done cycle", v), fd_q[0], c0 + 42);
            check($sformatf("vec%0d byte count", v), obs_byte.size(), 6);
            push_frame(c0 + 2, vecs[v].c_mil, vecs[v].c_cen, vecs[v].c_dec, vecs[v].c_uni);
            compare_obs($sformatf("vec%0d", v));
            tick();
            check($sformatf("vec%0d idle busy", v), busy, 1'b0);
        end

        // Input change in the middle of a frame is deferred to the following frame.
        clear_obs();
        c0 = cyc;
        uni = 4'd1;
        repeat (9) tick();
        check("midchange in byte1 strobe", {lcd_e, lcd_rs, lcd_data}, {1'b1, 1'b1, 8'h30});
        cen = 4'd4;
        wait_fd(100, "midchange frame_done");
        if (fd_q.size() > 0) check("midchange frame_done cycle", fd_q[0], c0 + 42);
        push_frame(c0 + 2, 8'h30, 8'h3F, 8'h37, 8'h31);
        compare_obs("midchange old");
        clear_obs();
        tick();
        check("midchange idle busy", busy, 1'b0);
        tick();
        check("midchange refresh busy", busy, 1'b1);
        wait_fd(100, "midchange refresh frame_done");
        if (fd_q.size() > 0) check("midchange refresh frame_done cycle", fd_q[0], c0 + 85);
        push_frame(c0 + 45, 8'h30, 8'h34, 8'h37, 8'h31);
        compare_obs("midchange new");

        // Reset during an enable pulse, then a full restart.
        tick();
        uni = 4'd2;
        n = 0;
        while (!lcd_e && n < 20) begin
            tick();
            n++;
        end
        if (!lcd_e) fail("midreset wait lcd_e", "lcd_e never rose");
        reset = 1'b1;
        #1;
        check("midreset lcd_e drop", lcd_e, 1'b0);
        check("midreset busy", busy, 1'b1);
        repeat (3) tick();
        check_reset_outputs("midreset");
        clear_obs();
        reset = 1'b0;
        check_power_up("restart", 8'h30, 8'h34, 8'h37, 8'h32);

        check("lcd_e hold violations", hold_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
